// File: rtl/counter_rev_cascade.sv
// Reversible up/down counter slice with wrap limit, parallel load,
// sticky wrap flag and ripple carry/borrow for chaining slices.
module counter_rev_cascade #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             Rc,
  output logic             ovf
);

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic             wrap;
  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    step   = en & cin;
    at_top = (Q >= limit);
    at_bot = (Q == '0);
    Rc     = step & (up ? at_top : at_bot);
    // a load on the same edge overrides the step, so it is not a wrap
    wrap   = Rc & ~load;
  end

  always_comb begin
    q_nxt = Q;
    if (load)
      q_nxt = din;
    else if (wrap)
      q_nxt = up ? '0 : limit;
    else if (step)
      q_nxt = up ? Q + WIDTH'(1) : Q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else begin
      Q <= q_nxt;
      // set beats clear so a wrap on the clearing edge is kept
      if (wrap)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_rev_cascade.sv
// Directed bench: single slice behaviour plus a two-slice
// 8-bit cascade, all expectations hand-computed.
module tb_counter_rev_cascade;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, cin, up, load, ovf_clr;
  logic [3:0] din, limit;
  logic [3:0] q;
  logic       rc, ovf;

  logic       c_en, c_up, c_load;
  logic [7:0] c_din;
  logic [3:0] lo_q, hi_q;
  logic       lo_rc, hi_rc, lo_ovf, hi_ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  counter_rev_cascade #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cin(cin), .up(up),
    .load(load), .din(din), .limit(limit), .ovf_clr(ovf_clr),
    .Q(q), .Rc(rc), .ovf(ovf)
  );

  counter_rev_cascade #(.WIDTH(4)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(c_en), .cin(1'b1), .up(c_up),
    .load(c_load), .din(c_din[3:0]), .limit(4'hF),
    .ovf_clr(1'b0), .Q(lo_q), .Rc(lo_rc), .ovf(lo_ovf)
  );

  counter_rev_cascade #(.WIDTH(4)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(c_en), .cin(lo_rc), .up(c_up),
    .load(c_load), .din(c_din[7:4]), .limit(4'hF),
    .ovf_clr(1'b0), .Q(hi_q), .Rc(hi_rc), .ovf(hi_ovf)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] dn_q   [5];
    logic       dn_ovf [5];
    dn_q   = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    dn_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    en = 0; cin = 1; up = 1; load = 0; ovf_clr = 0;
    din = 0; limit = 4'd15;
    c_en = 0; c_up = 1; c_load = 0; c_din = 0;
    #3;
    check("rst_q", q, 0);
    check("rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;

    en = 1;
    repeat (5) tick();
    check("pre_rst_q", q, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_q", q, 1);

    // up wrap at limit 9
    limit = 4'd9; load = 1; din = 0;
    tick();
    load = 0;
    for (int i = 0; i < 10; i++) begin
      check("up_q", q, i);
      check("up_rc", rc, (i == 9));
      check("up_ovf", ovf, 0);
      tick();
    end
    check("up_wrap_q", q, 0);
    check("up_wrap_ovf", ovf, 1);
    tick();
    check("up_after_q", q, 1);
    check("ovf_sticky", ovf, 1);

    en = 0; ovf_clr = 1;
    tick();
    check("ovf_clr", ovf, 0);
    ovf_clr = 0;

    // down wrap
    en = 1; up = 0; load = 1; din = 4'd2;
    tick();
    load = 0;
    for (int i = 0; i < 5; i++) begin
      check("dn_q", q, dn_q[i]);
      check("dn_rc", rc, (dn_q[i] == 0));
      check("dn_ovf", ovf, dn_ovf[i]);
      if (i < 4) tick();
    end

    en = 0; ovf_clr = 1;
    tick();
    ovf_clr = 0;
    check("ovf_clr2", ovf, 0);

    // load above limit, with en asserted
    en = 1; up = 1; load = 1; din = 4'd12;
    tick();
    load = 0;
    check("load_pri_q", q, 12);
    check("load_ovf", ovf, 0);
    check("above_rc", rc, 1);
    tick();
    check("above_wrap_q", q, 0);
    check("above_wrap_ovf", ovf, 1);

    up = 0; load = 1; din = 4'd12;
    tick();
    load = 0;
    check("dn_load_q", q, 12);
    check("dn_above_rc", rc, 0);
    tick();
    check("dn_above_q", q, 11);

    // clear alone, then clear together with a wrap
    en = 0; ovf_clr = 1; load = 1; din = 4'd9;
    tick();
    load = 0;
    check("clr_alone_ovf", ovf, 0);
    check("clr_alone_q", q, 9);
    en = 1; up = 1;
    tick();
    check("clr_wrap_q", q, 0);
    check("clr_wrap_ovf", ovf, 1);
    en = 0;
    tick();
    check("clr_again_ovf", ovf, 0);
    ovf_clr = 0;

    // limit 0
    limit = 0; en = 1; up = 1;
    #1;
    check("lim0_rc", rc, 1);
    tick();
    check("lim0_q", q, 0);
    check("lim0_ovf", ovf, 1);
    check("lim0_rc2", rc, 1);
    up = 0;
    #1;
    check("lim0_dn_rc", rc, 1);
    tick();
    check("lim0_dn_q", q, 0);
    en = 0;
    #1;
    check("lim0_idle_rc", rc, 0);

    // two-slice cascade
    c_load = 1; c_din = 8'h0E;
    tick();
    c_load = 0; c_en = 1; c_up = 1;
    check("cas_load", {hi_q, lo_q}, 8'h0E);
    tick();
    check("cas_0f", {hi_q, lo_q}, 8'h0F);
    check("cas_lo_rc", lo_rc, 1);
    check("cas_hi_rc", hi_rc, 0);
    tick();
    check("cas_10", {hi_q, lo_q}, 8'h10);
    c_up = 0;
    #1;
    check("cas_borrow", lo_rc, 1);
    tick();
    check("cas_dn_0f", {hi_q, lo_q}, 8'h0F);
    c_en = 0;
    tick();
    check("cas_hold", {hi_q, lo_q}, 8'h0F);
    check("cas_hold_lo_rc", lo_rc, 0);
    check("cas_hold_hi_rc", hi_rc, 0);
    check("cas_ovf", {hi_ovf, lo_ovf}, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
